// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory command port between NUM_CH requesting channels
// (channel 0 = cart, channel 1 = USB). One transaction is in flight at a time:
//   IDLE    : pick a winner among the active requests and latch its command.
//   ISSUE   : wait for the matching ready, then strobe mem_rd / mem_wr once.
//   WAIT    : wait for completion; a dropped ready means the memory aborted,
//             so the command is reissued.
//   RELEASE : channels flagged in HOLD_MASK keep the grant until they drop
//             their request; the others give it up on the next cycle.
// A cycle counter bounds the time spent in ISSUE/WAIT and reports ch_err.
//
// Parameters
//   NUM_CH    number of channels (2..8)
//   ADDR_W    memory byte-address width
//   DATA_W    memory data width
//   RR_EN     1 = round-robin, 0 = fixed priority (lowest index wins)
//   HOLD_MASK per-channel "keep grant until request drops"
//   TIMEOUT   cycle limit for one transaction
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ch_rd / ch_wr         per-channel read / write request levels
//   ch_addr / ch_width    per-channel address and width code, flattened
//   ch_wr_data            per-channel write data, flattened
//   ch_rd_data            shared read data, held until the next read completes
//   ch_rd_valid           per-channel one-cycle read-complete pulse
//   ch_wr_done            per-channel one-cycle write-complete pulse
//   ch_err                per-channel one-cycle timeout pulse
//   mem_rd / mem_wr       one-cycle command strobes
//   mem_addr, mem_data_width, mem_wr_data   latched command fields
//   mem_rd_ready / mem_wr_ready             memory can accept a command
//   mem_rd_valid / mem_rd_data              read return
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int                NUM_CH    = 2,
    parameter int                ADDR_W    = 26,
    parameter int                DATA_W    = 32,
    parameter bit                RR_EN     = 1'b1,
    parameter logic [NUM_CH-1:0] HOLD_MASK = {{(NUM_CH-1){1'b0}}, 1'b1},
    parameter int                TIMEOUT   = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_rd,
    input  logic [NUM_CH-1:0]        ch_wr,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*2-1:0]      ch_width,
    input  logic [NUM_CH*DATA_W-1:0] ch_wr_data,
    output logic [DATA_W-1:0]        ch_rd_data,
    output logic [NUM_CH-1:0]        ch_rd_valid,
    output logic [NUM_CH-1:0]        ch_wr_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [1:0]               mem_data_width,
    output logic [DATA_W-1:0]        mem_wr_data,
    input  logic                     mem_rd_ready,
    input  logic                     mem_wr_ready,
    input  logic                     mem_rd_valid,
    input  logic [DATA_W-1:0]        mem_rd_data
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Registered state and latched command
    state_t             state_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   last_q;
    logic               op_wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [1:0]         width_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [CNT_W-1:0]   cnt_q;

    // Registered outputs
    logic [DATA_W-1:0]  rd_data_q;
    logic [NUM_CH-1:0]  rd_vld_q;
    logic [NUM_CH-1:0]  wr_done_q;
    logic [NUM_CH-1:0]  err_q;
    logic               mem_rd_q;
    logic               mem_wr_q;

    // Arbitration result and the command it would latch
    logic [NUM_CH-1:0]  req;
    logic               win_found;
    logic [IDX_W-1:0]   grant_d;
    logic               op_wr_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [1:0]         width_d;
    logic [DATA_W-1:0]  wdata_d;
    int                 cand;
    logic [IDX_W-1:0]   cand_idx;

    logic               timeout;
    logic               op_ready;

    assign req      = ch_rd | ch_wr;
    assign timeout  = (cnt_q == CNT_LAST);
    assign op_ready = op_wr_q ? mem_wr_ready : mem_rd_ready;

    // Scan the channels in search order; round-robin starts just past the
    // last granted channel, fixed priority always starts at channel 0.
    always_comb begin
        win_found = 1'b0;
        grant_d   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_EN) begin
                cand = (int'(last_q) + 1 + k) % NUM_CH;
            end else begin
                cand = k;
            end
            cand_idx = IDX_W'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                grant_d   = cand_idx;
            end
        end
    end

    // Pick out the winner's command fields. A channel asking for both a read
    // and a write is served as a read, and reads carry zero write data.
    always_comb begin
        op_wr_d = 1'b0;
        addr_d  = '0;
        width_d = '0;
        wdata_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_d == IDX_W'(i)) begin
                op_wr_d = ~ch_rd[i];
                addr_d  = ch_addr[i*ADDR_W +: ADDR_W];
                width_d = ch_width[i*2 +: 2];
                wdata_d = ch_rd[i] ? '0 : ch_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= LAST_RST;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            width_q   <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= '0;
            wr_done_q <= '0;
            err_q     <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
        end else begin
            // All strobes and completion flags are single-cycle pulses.
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            rd_vld_q  <= '0;
            wr_done_q <= '0;
            err_q     <= '0;

            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        grant_q <= grant_d;
                        op_wr_q <= op_wr_d;
                        addr_q  <= addr_d;
                        width_q <= width_d;
                        wdata_q <= wdata_d;
                        cnt_q   <= '0;
                        state_q <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (timeout) begin
                        err_q[grant_q] <= 1'b1;
                        state_q        <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (op_ready) begin
                            mem_rd_q <= ~op_wr_q;
                            mem_wr_q <= op_wr_q;
                            state_q  <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    // Completion is checked before the timeout so a
                    // transaction finishing on its last cycle still succeeds.
                    if (!op_wr_q && mem_rd_valid) begin
                        rd_data_q         <= mem_rd_data;
                        rd_vld_q[grant_q] <= 1'b1;
                        state_q           <= RELEASE;
                    end else if (op_wr_q && mem_wr_ready) begin
                        wr_done_q[grant_q] <= 1'b1;
                        state_q            <= RELEASE;
                    end else if (timeout) begin
                        err_q[grant_q] <= 1'b1;
                        state_q        <= RELEASE;
                    end else if (!op_ready) begin
                        // Memory dropped ready: it aborted, so reissue.
                        cnt_q   <= '0;
                        state_q <= ISSUE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RELEASE: begin
                    if (!(HOLD_MASK[grant_q] && (ch_rd[grant_q] || ch_wr[grant_q]))) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign ch_rd_data     = rd_data_q;
    assign ch_rd_valid    = rd_vld_q;
    assign ch_wr_done     = wr_done_q;
    assign ch_err         = err_q;
    assign mem_rd         = mem_rd_q;
    assign mem_wr         = mem_wr_q;
    assign mem_addr       = addr_q;
    assign mem_data_width = width_q;
    assign mem_wr_data    = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT A: 2 channels, RR, ch0 holds, TIMEOUT 16 ----------
    logic            a_rst_n;
    logic [1:0]      a_rd, a_wr;
    logic [2*AW-1:0] a_addr;
    logic [3:0]      a_width;
    logic [2*DW-1:0] a_wdata;
    logic [DW-1:0]   a_rdata;
    logic [1:0]      a_rvld, a_wdone, a_err;
    logic            a_mrd, a_mwr;
    logic [AW-1:0]   a_maddr;
    logic [1:0]      a_mwidth;
    logic [DW-1:0]   a_mwdata;
    logic            a_rrdy, a_wrdy, a_mrvld;
    logic [DW-1:0]   a_mrdata;

    mem_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1),
                  .HOLD_MASK(2'b01), .TIMEOUT(16)) u_a (
        .clk(clk), .rst_n(a_rst_n), .ch_rd(a_rd), .ch_wr(a_wr),
        .ch_addr(a_addr), .ch_width(a_width), .ch_wr_data(a_wdata),
        .ch_rd_data(a_rdata), .ch_rd_valid(a_rvld), .ch_wr_done(a_wdone),
        .ch_err(a_err), .mem_rd(a_mrd), .mem_wr(a_mwr), .mem_addr(a_maddr),
        .mem_data_width(a_mwidth), .mem_wr_data(a_mwdata),
        .mem_rd_ready(a_rrdy), .mem_wr_ready(a_wrdy),
        .mem_rd_valid(a_mrvld), .mem_rd_data(a_mrdata));

    // ------------- DUT B (RR) and DUT C (fixed), 4 channels, no hold ------
    logic            rst_n;
    logic [3:0]      b_rd, b_wr, c_rd, c_wr;
    logic [4*AW-1:0] b_addr;
    logic [7:0]      b_width;
    logic [4*DW-1:0] b_wdata;
    logic            b_rrdy, b_wrdy, b_mrvld;
    logic [DW-1:0]   b_mrdata;

    logic [DW-1:0]   b_rdata, c_rdata;
    logic [3:0]      b_rvld, b_wdone, b_err, c_rvld, c_wdone, c_err;
    logic            b_mrd, b_mwr, c_mrd, c_mwr;
    logic [AW-1:0]   b_maddr, c_maddr;
    logic [1:0]      b_mwidth, c_mwidth;
    logic [DW-1:0]   b_mwdata, c_mwdata;

    mem_arbiter #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1),
                  .HOLD_MASK(4'b0000), .TIMEOUT(1024)) u_b (
        .clk(clk), .rst_n(rst_n), .ch_rd(b_rd), .ch_wr(b_wr),
        .ch_addr(b_addr), .ch_width(b_width), .ch_wr_data(b_wdata),
        .ch_rd_data(b_rdata), .ch_rd_valid(b_rvld), .ch_wr_done(b_wdone),
        .ch_err(b_err), .mem_rd(b_mrd), .mem_wr(b_mwr), .mem_addr(b_maddr),
        .mem_data_width(b_mwidth), .mem_wr_data(b_mwdata),
        .mem_rd_ready(b_rrdy), .mem_wr_ready(b_wrdy),
        .mem_rd_valid(b_mrvld), .mem_rd_data(b_mrdata));

    mem_arbiter #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0),
                  .HOLD_MASK(4'b0000), .TIMEOUT(1024)) u_c (
        .clk(clk), .rst_n(rst_n), .ch_rd(c_rd), .ch_wr(c_wr),
        .ch_addr(b_addr), .ch_width(b_width), .ch_wr_data(b_wdata),
        .ch_rd_data(c_rdata), .ch_rd_valid(c_rvld), .ch_wr_done(c_wdone),
        .ch_err(c_err), .mem_rd(c_mrd), .mem_wr(c_mwr), .mem_addr(c_maddr),
        .mem_data_width(c_mwidth), .mem_wr_data(c_mwdata),
        .mem_rd_ready(b_rrdy), .mem_wr_ready(b_wrdy),
        .mem_rd_valid(b_mrvld), .mem_rd_data(b_mrdata));

    // Reference-model round-robin pointer for DUT B
    int m_last_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; rst_n = 1'b0;
        a_rd = '0; a_wr = '0; a_addr = '0; a_width = '0; a_wdata = '0;
        a_rrdy = 1'b1; a_wrdy = 1'b1; a_mrvld = 1'b0; a_mrdata = '0;
        b_rd = '0; b_wr = '0; c_rd = '0; c_wr = '0;
        b_addr = '0; b_width = '0; b_wdata = '0;
        b_rrdy = 1'b1; b_wrdy = 1'b1; b_mrvld = 1'b0; b_mrdata = '0;
        m_last_b = 3;
        repeat (3) tick();
        for (int pass = 0; pass < 2; pass++) begin
            total++;
            if ({a_rdata, a_rvld, a_wdone, a_err, a_mrd, a_mwr, a_maddr, a_mwidth, a_mwdata} !== '0) begin
                bad++; $display("FAIL reset_a pass=%0d got mrd=%b addr=%h rdata=%h exp all zero", pass, a_mrd, a_maddr, a_rdata);
            end
            total++;
            if ({b_rdata, b_rvld, b_wdone, b_err, b_mrd, b_mwr, b_maddr, b_mwidth, b_mwdata} !== '0) begin
                bad++; $display("FAIL reset_b pass=%0d got mrd=%b addr=%h exp all zero", pass, b_mrd, b_maddr);
            end
            total++;
            if ({c_rdata, c_rvld, c_wdone, c_err, c_mrd, c_mwr, c_maddr, c_mwidth, c_mwdata} !== '0) begin
                bad++; $display("FAIL reset_c pass=%0d got mrd=%b addr=%h exp all zero", pass, c_mrd, c_maddr);
            end
            a_rst_n = 1'b1; rst_n = 1'b1;
            repeat (2) tick();
        end
    endtask

    task automatic test_single_read();
        bit found;
        int mrd_cnt, rv_cnt;
        a_addr = '0; a_addr[0 +: AW] = 26'h0000100;
        a_width = 4'b0010;
        a_rd = 2'b01;
        found = 0; mrd_cnt = 0; rv_cnt = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (a_mrd) begin found = 1; mrd_cnt++; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL sr_issue got no mem_rd exp mem_rd within 20 cycles"); end
        total++;
        if (a_maddr !== 26'h0000100 || a_mwidth !== 2'b10 || a_mwdata !== '0) begin
            bad++; $display("FAIL sr_cmd got addr=%h width=%b wdata=%h exp 0000100/10/0", a_maddr, a_mwidth, a_mwdata);
        end
        a_mrdata = 32'h0000BEEF; a_mrvld = 1'b1;
        tick();
        a_mrvld = 1'b0; a_mrdata = 32'hDEAD0000;
        total++;
        if (a_rvld !== 2'b01 || a_rdata !== 32'h0000BEEF) begin
            bad++; $display("FAIL sr_rvld got rvld=%b rdata=%h exp 01/0000beef", a_rvld, a_rdata);
        end
        // ch_rd[0] stays high: channel 0 must keep the grant (no new command)
        for (int n = 0; n < 6; n++) begin
            tick();
            if (a_mrd) mrd_cnt++;
            if (a_rvld != 0) rv_cnt++;
        end
        total++;
        if (mrd_cnt !== 1 || rv_cnt !== 0) begin
            bad++; $display("FAIL sr_hold got mrd_pulses=%0d extra_rvld=%0d exp 1/0", mrd_cnt, rv_cnt);
        end
        a_rd = 2'b00;
        repeat (3) tick();
        total++;
        if (a_rdata !== 32'h0000BEEF) begin
            bad++; $display("FAIL sr_rdata_hold got %h exp 0000beef", a_rdata);
        end
    endtask

    task automatic test_timeout();
        int err_at, err_cnt, rv_cnt;
        logic [1:0] err_val;
        err_at = -1; err_cnt = 0; rv_cnt = 0; err_val = '0;
        a_addr[AW +: AW] = AW'($urandom);
        a_rd = 2'b10;
        // The grant edge (first tick) enters ISSUE; the error is due 16 cycles later.
        for (int n = 1; n <= 24; n++) begin
            tick();
            if (a_err != 0) begin
                if (err_at < 0) err_at = n;
                err_cnt++;
                err_val = a_err;
                a_rd = 2'b00;
            end
            if (a_rvld != 0) rv_cnt++;
        end
        total++;
        if (err_at !== 17) begin bad++; $display("FAIL to_cycle got %0d exp 17", err_at); end
        total++;
        if (err_cnt !== 1 || err_val !== 2'b10) begin
            bad++; $display("FAIL to_pulse got count=%0d bits=%b exp 1/10", err_cnt, err_val);
        end
        total++;
        if (rv_cnt !== 0) begin bad++; $display("FAIL to_no_rvld got %0d exp 0", rv_cnt); end
    endtask

    task automatic test_reissue();
        bit found;
        int mrd_cnt, rv_cnt;
        logic [DW-1:0] d;
        mrd_cnt = 0; rv_cnt = 0;
        a_addr[0 +: AW] = AW'($urandom);
        a_rd = 2'b01;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (a_mrd) begin found = 1; mrd_cnt++; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL ri_first got no mem_rd exp one"); end
        a_rrdy = 1'b0;
        repeat (3) begin
            tick();
            if (a_mrd) mrd_cnt++;
        end
        a_rrdy = 1'b1;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (a_mrd) begin found = 1; mrd_cnt++; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL ri_second got no reissued mem_rd exp one"); end
        d = $urandom;
        a_mrdata = d; a_mrvld = 1'b1;
        tick();
        a_mrvld = 1'b0;
        if (a_rvld != 0) rv_cnt++;
        total++;
        if (a_rvld !== 2'b01 || a_rdata !== d) begin
            bad++; $display("FAIL ri_data got rvld=%b rdata=%h exp 01/%h", a_rvld, a_rdata, d);
        end
        a_rd = 2'b00;
        repeat (4) begin
            tick();
            if (a_mrd) mrd_cnt++;
            if (a_rvld != 0) rv_cnt++;
        end
        total++;
        if (mrd_cnt !== 2 || rv_cnt !== 1) begin
            bad++; $display("FAIL ri_counts got mrd=%0d rvld=%0d exp 2/1", mrd_cnt, rv_cnt);
        end
    endtask

    task automatic test_reset_in_wait();
        bit found;
        int pulse_cnt;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d;
        a0 = AW'($urandom); a1 = ~a0;
        a_addr = {a1, a0};
        a_rd = 2'b11;
        pulse_cnt = 0;
        // Channel 0 was served last, so round-robin must pick channel 1 first.
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (a_mrd) found = 1;
        end
        total++;
        if (!found || a_maddr !== a1) begin
            bad++; $display("FAIL rw_first got found=%0d addr=%h exp addr=%h", found, a_maddr, a1);
        end
        repeat (2) tick();
        #3;
        a_rst_n = 1'b0;
        #1;
        total++;
        if ({a_rdata, a_rvld, a_wdone, a_err, a_mrd, a_mwr, a_maddr, a_mwidth, a_mwdata} !== '0) begin
            bad++; $display("FAIL rw_async got addr=%h rdata=%h exp all zero", a_maddr, a_rdata);
        end
        tick();
        a_rst_n = 1'b1;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (a_rvld != 0 || a_err != 0 || a_wdone != 0) pulse_cnt++;
            if (a_mrd) found = 1;
        end
        total++;
        if (!found || a_maddr !== a0) begin
            bad++; $display("FAIL rw_regrant got found=%0d addr=%h exp addr=%h", found, a_maddr, a0);
        end
        total++;
        if (pulse_cnt !== 0) begin bad++; $display("FAIL rw_no_pulse got %0d exp 0", pulse_cnt); end
        d = $urandom;
        a_mrdata = d; a_mrvld = 1'b1;
        tick();
        a_mrvld = 1'b0;
        total++;
        if (a_rvld !== 2'b01 || a_rdata !== d) begin
            bad++; $display("FAIL rw_done got rvld=%b rdata=%h exp 01/%h", a_rvld, a_rdata, d);
        end
        a_rd = 2'b00;
        repeat (3) tick();
    endtask

    task automatic test_rr_writes();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        int done_cnt, ch;
        int per_bit [4] = '{0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            b_addr[i*AW +: AW]  = AW'($urandom);
            b_wdata[i*DW +: DW] = $urandom;
        end
        b_width = 8'($urandom);
        b_rrdy = 1'b1; b_wrdy = 1'b1;
        b_wr = 4'hF;
        done_cnt = 0;
        for (int n = 0; n < 80 && done_cnt < 5; n++) begin
            tick();
            if (b_mwr) begin
                ch = exp_seq[done_cnt];
                total++;
                if (b_mwdata !== b_wdata[ch*DW +: DW] || b_maddr !== b_addr[ch*AW +: AW]) begin
                    bad++; $display("FAIL rr_cmd%0d got addr=%h data=%h exp ch%0d addr=%h data=%h",
                        done_cnt, b_maddr, b_mwdata, ch, b_addr[ch*AW +: AW], b_wdata[ch*DW +: DW]);
                end
            end
            if (b_wdone != 0) begin
                ch = exp_seq[done_cnt];
                total++;
                if (b_wdone !== 4'(1 << ch)) begin
                    bad++; $display("FAIL rr_done%0d got %b exp ch%0d", done_cnt, b_wdone, ch);
                end
                if (done_cnt < 4) begin
                    for (int i = 0; i < 4; i++) if (b_wdone[i]) per_bit[i]++;
                end
                done_cnt++;
                if (done_cnt == 5) b_wr = 4'h0;
            end
        end
        b_wr = 4'h0;
        total++;
        if (done_cnt !== 5) begin bad++; $display("FAIL rr_count got %0d exp 5", done_cnt); end
        total++;
        if (per_bit[0] !== 1 || per_bit[1] !== 1 || per_bit[2] !== 1 || per_bit[3] !== 1) begin
            bad++; $display("FAIL rr_round got %0d%0d%0d%0d exp 1111", per_bit[0], per_bit[1], per_bit[2], per_bit[3]);
        end
        m_last_b = 0;
        repeat (4) tick();
    endtask

    task automatic test_fixed_prio();
        bit found;
        int ch2_cnt;
        logic [DW-1:0] d;
        for (int i = 0; i < 4; i++) b_addr[i*AW +: AW] = AW'($urandom);
        ch2_cnt = 0;
        c_rd = 4'b0110;
        for (int r = 0; r < 5; r++) begin
            found = 0;
            for (int n = 0; n < 20 && !found; n++) begin
                tick();
                if (c_rvld[2]) ch2_cnt++;
                if (c_mrd) found = 1;
            end
            total++;
            if (!found || c_maddr !== b_addr[1*AW +: AW]) begin
                bad++; $display("FAIL fp_grant%0d got found=%0d addr=%h exp ch1 addr=%h", r, found, c_maddr, b_addr[1*AW +: AW]);
            end
            d = $urandom;
            b_mrdata = d; b_mrvld = 1'b1;
            tick();
            b_mrvld = 1'b0;
            total++;
            if (c_rvld !== 4'b0010 || c_rdata !== d) begin
                bad++; $display("FAIL fp_done%0d got rvld=%b rdata=%h exp 0010/%h", r, c_rvld, c_rdata, d);
            end
        end
        c_rd = 4'b0000;
        repeat (4) begin
            tick();
            if (c_rvld[2]) ch2_cnt++;
        end
        total++;
        if (ch2_cnt !== 0) begin bad++; $display("FAIL fp_starve got ch2 served %0d exp 0", ch2_cnt); end
    endtask

    task automatic test_random();
        logic [3:0] req, rdv, wrv;
        int win, dly;
        bit is_rd, found;
        logic [AW-1:0] e_addr;
        logic [1:0]    e_width;
        logic [DW-1:0] e_wdata, d;
        logic [3:0]    got_pulse, got_err;
        for (int it = 0; it < 24; it++) begin
            req = 4'($urandom_range(1, 15));
            rdv = 4'($urandom) & req;
            wrv = (req & ~rdv) | (4'($urandom) & req);
            for (int i = 0; i < 4; i++) begin
                b_addr[i*AW +: AW]  = AW'($urandom);
                b_wdata[i*DW +: DW] = $urandom;
            end
            b_width = 8'($urandom);
            // Model: first requester after the last grant, reads win over writes
            win = -1;
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && req[(m_last_b + 1 + k) % 4]) win = (m_last_b + 1 + k) % 4;
            end
            is_rd   = rdv[win];
            e_addr  = b_addr[win*AW +: AW];
            e_width = b_width[win*2 +: 2];
            e_wdata = is_rd ? '0 : b_wdata[win*DW +: DW];
            dly = $urandom_range(0, 3);
            b_rrdy = (dly == 0); b_wrdy = (dly == 0);
            b_rd = rdv; b_wr = wrv;
            found = 0;
            for (int n = 0; n < 30 && !found; n++) begin
                tick();
                if (n + 1 >= dly) begin b_rrdy = 1'b1; b_wrdy = 1'b1; end
                if (b_mrd || b_mwr) found = 1;
            end
            total++;
            if (!found || b_mrd !== is_rd || b_mwr !== !is_rd || b_maddr !== e_addr
                || b_mwidth !== e_width || b_mwdata !== e_wdata) begin
                bad++; $display("FAIL rnd_cmd%0d got rd=%b wr=%b addr=%h w=%b data=%h exp ch%0d rd=%0d addr=%h w=%b data=%h",
                    it, b_mrd, b_mwr, b_maddr, b_mwidth, b_mwdata, win, is_rd, e_addr, e_width, e_wdata);
            end
            // Requests drop mid-transaction; the transaction must still finish.
            b_rd = '0; b_wr = '0;
            d = $urandom;
            if (is_rd) begin
                repeat ($urandom_range(0, 3)) tick();
                b_mrdata = d; b_mrvld = 1'b1;
            end
            got_pulse = '0; got_err = '0;
            for (int n = 0; n < 10 && got_pulse == 0 && got_err == 0; n++) begin
                tick();
                b_mrvld = 1'b0;
                got_pulse = b_rvld | b_wdone;
                got_err   = b_err;
            end
            total++;
            if (got_pulse !== 4'(1 << win) || got_err !== 4'b0000
                || (is_rd && (b_rvld !== 4'(1 << win) || b_rdata !== d))
                || (!is_rd && b_wdone !== 4'(1 << win))) begin
                bad++; $display("FAIL rnd_done%0d got rvld=%b wdone=%b err=%b rdata=%h exp ch%0d rd=%0d data=%h",
                    it, b_rvld, b_wdone, b_err, b_rdata, win, is_rd, d);
            end
            m_last_b = win;
            repeat (2) tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_timeout();
        test_reissue();
        test_reset_in_wait();
        test_rr_writes();
        test_fixed_prio();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
